// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with sequenced clear (optional forwarding: REG_FILE_MP_BYPASS_EN)
module reg_file_mp #(
    parameter int addr_width_p = 6,
    parameter int data_width_p = 32,
    parameter int num_read_p   = 2,
    parameter int zero_reg_p   = 0
) (
    input  logic                                      clk,
    input  logic                                      reset_n_i,
    input  logic                                      clear_i,
    input  logic                                      wen_i,
    input  logic [addr_width_p-1:0]                   write_addr_i,
    input  logic [data_width_p-1:0]                   write_data_i,
    input  logic [num_read_p-1:0][addr_width_p-1:0]   read_addr_i,
    output logic [num_read_p-1:0][data_width_p-1:0]   read_data_o,
    output logic                                      ready_o,
    output logic                                      wr_drop_o
);

    localparam int depth_lp = 1 << addr_width_p;

    localparam logic [0:0] state_clear_lp = 1'b0;
    localparam logic [0:0] state_ready_lp = 1'b1;

    localparam logic [addr_width_p-1:0] cnt_last_lp = {addr_width_p{1'b1}};
    localparam logic [addr_width_p-1:0] cnt_one_lp  = {{(addr_width_p-1){1'b0}}, 1'b1};

    logic [0:0]              state_q, state_d;
    logic [addr_width_p-1:0] clr_cnt_q, clr_cnt_d;
    logic                    wr_drop_q, wr_drop_d;

    logic [data_width_p-1:0] mem_q [depth_lp];

    logic                    mem_wen;
    logic [addr_width_p-1:0] mem_waddr;
    logic [data_width_p-1:0] mem_wdata;
    logic                    wr_to_zero;
    logic                    wr_accept;

    // Entry 0 is hardwired when the zero register is enabled; writes to it vanish silently.
    assign wr_to_zero = (zero_reg_p != 0) && (write_addr_i == '0);
    assign wr_accept  = (state_q == state_ready_lp) && wen_i && !clear_i && !wr_to_zero;

    // Next-state, clear sequencing and write-port arbitration (clear always beats a write).
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_drop_d = wen_i && !wr_to_zero && ((state_q == state_clear_lp) || clear_i);
        mem_wen   = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        case (state_q)
            state_clear_lp: begin
                mem_wen = 1'b1;
                if (clear_i) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == cnt_last_lp) begin
                    state_d   = state_ready_lp;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + cnt_one_lp;
                end
            end
            default: begin
                if (clear_i) begin
                    state_d   = state_clear_lp;
                    clr_cnt_d = '0;
                end else if (wr_accept) begin
                    mem_wen   = 1'b1;
                    mem_waddr = write_addr_i;
                    mem_wdata = write_data_i;
                end
            end
        endcase
    end

    // Control state: reset aborts whatever is in flight and restarts the clear from entry 0.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= state_clear_lp;
            clr_cnt_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array: no reset, only the clear sequence or accepted writes touch it.
    always_ff @(posedge clk) begin
        if (mem_wen && reset_n_i) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Asynchronous read ports; zero while clearing, optional same-cycle forwarding of accepted writes.
    always_comb begin
        for (int p = 0; p < num_read_p; p++) begin
            read_data_o[p] = mem_q[read_addr_i[p]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_accept && (read_addr_i[p] == write_addr_i)) begin
                read_data_o[p] = write_data_i;
            end
`endif
            if ((state_q == state_clear_lp) || ((zero_reg_p != 0) && (read_addr_i[p] == '0))) begin
                read_data_o[p] = '0;
            end
        end
    end

    assign ready_o   = (state_q == state_ready_lp);
    assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (default and zero-register instances)
module tb_reg_file_mp;

    logic             clk;
    logic             reset_n;

    logic             clear1, wen1;
    logic [5:0]       waddr1;
    logic [31:0]      wdata1;
    logic [1:0][5:0]  raddr1;
    logic [1:0][31:0] rdata1;
    logic             ready1, drop1;

    logic             clear2, wen2;
    logic [5:0]       waddr2;
    logic [31:0]      wdata2;
    logic [1:0][5:0]  raddr2;
    logic [1:0][31:0] rdata2;
    logic             ready2, drop2;

    int checks;
    int errors;

    string       tag_q[$];
    int          port_q[$];
    logic [31:0] exp_q[$];

    reg_file_mp dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .clear_i      (clear1),
        .wen_i        (wen1),
        .write_addr_i (waddr1),
        .write_data_i (wdata1),
        .read_addr_i  (raddr1),
        .read_data_o  (rdata1),
        .ready_o      (ready1),
        .wr_drop_o    (drop1)
    );

    reg_file_mp #(.zero_reg_p(1)) dut_zr (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .clear_i      (clear2),
        .wen_i        (wen2),
        .write_addr_i (waddr2),
        .write_data_i (wdata2),
        .read_addr_i  (raddr2),
        .read_data_o  (rdata2),
        .ready_o      (ready2),
        .wr_drop_o    (drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Ports 0/1 belong to dut, ports 2/3 to dut_zr.
    task automatic sb_push(input string tag, input int port, input logic [31:0] exp);
        tag_q.push_back(tag);
        port_q.push_back(port);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check();
        string       t;
        int          p;
        logic [31:0] e;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            p = port_q.pop_front();
            e = exp_q.pop_front();
            case (p)
                0:       got = rdata1[0];
                1:       got = rdata1[1];
                2:       got = rdata2[0];
                default: got = rdata2[1];
            endcase
            check_value(t, got, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clear1 = 1'b0; wen1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
        clear2 = 1'b0; wen2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

        // Initial reset, then let a clear run partway before aborting it with a mid-cycle pulse.
        step();
        step();
        #3 reset_n = 1'b1;
        repeat (10) step();
        #3 reset_n = 1'b0;
        #1;
        check_value("rst_ready", {31'b0, ready1}, 32'd0);
        check_value("rst_drop", {31'b0, drop1}, 32'd0);
        raddr1[0] = 6'd3;
        #1;
        sb_push("rst_rd", 0, 32'd0);
        sb_check();
        step();
        #3 reset_n = 1'b1;

        for (int k = 1; k <= 64; k++) begin
            step();
            raddr1[0] = 6'($urandom_range(0, 63));
            raddr1[1] = 6'($urandom_range(0, 63));
            check_value("boot_ready", {31'b0, ready1}, {31'b0, k == 64});
            if (k < 64) begin
                sb_push("boot_rd0", 0, 32'd0);
                sb_push("boot_rd1", 1, 32'd0);
                sb_check();
            end
        end
        check_value("boot_ready_zr", {31'b0, ready2}, 32'd1);

        for (int a = 0; a < 64; a++) begin
            raddr1[0] = 6'(a);
            raddr1[1] = 6'(63 - a);
            raddr2[0] = 6'(a);
            #1;
            sb_push("init_p0", 0, 32'd0);
            sb_push("init_p1", 1, 32'd0);
            sb_push("init_zr", 2, 32'd0);
            sb_check();
        end
        step();

        // Plain writes, visible on the following cycle; a neighbour stays untouched.
        wen1 = 1'b1; waddr1 = 6'd5;  wdata1 = 32'hDEADBEEF;
        step();
        waddr1 = 6'd63; wdata1 = 32'h12345678;
        step();
        wen1 = 1'b0;
        raddr1[0] = 6'd5; raddr1[1] = 6'd63;
        sb_push("wr_p0_5", 0, 32'hDEADBEEF);
        sb_push("wr_p1_63", 1, 32'h12345678);
        @(negedge clk);
        sb_check();
        raddr1[0] = 6'd4;
        #1;
        sb_push("wr_neighbour", 0, 32'd0);
        sb_check();
        step();

        // Same-cycle write/read of entry 9 while port 1 reads a different entry.
        wen1 = 1'b1; waddr1 = 6'd9; wdata1 = 32'hA5A5A5A5;
        raddr1[0] = 6'd9; raddr1[1] = 6'd5;
`ifdef REG_FILE_MP_BYPASS_EN
        sb_push("byp_same", 0, 32'hA5A5A5A5);
`else
        sb_push("byp_same", 0, 32'd0);
`endif
        sb_push("byp_other", 1, 32'hDEADBEEF);
        @(negedge clk);
        sb_check();
        step();
        wen1 = 1'b0;
        sb_push("byp_next", 0, 32'hA5A5A5A5);
        @(negedge clk);
        sb_check();
        check_value("byp_nodrop", {31'b0, drop1}, 32'd0);
        step();

        // Clear colliding with a write: write is dropped, full clear follows.
        clear1 = 1'b1; wen1 = 1'b1; waddr1 = 6'd3; wdata1 = 32'h000000FF;
        raddr1[0] = 6'd3;
        sb_push("coll_same_cycle", 0, 32'd0);
        @(negedge clk);
        sb_check();
        step();
        clear1 = 1'b0; wen1 = 1'b0;
        check_value("coll_drop", {31'b0, drop1}, 32'd1);
        check_value("coll_ready", {31'b0, ready1}, 32'd0);
        raddr1[1] = 6'd5;
        #1;
        sb_push("coll_rd_zero", 1, 32'd0);
        sb_check();
        for (int k = 1; k <= 64; k++) begin
            step();
            check_value("coll_drop_once", {31'b0, drop1}, 32'd0);
            check_value("coll_wait_ready", {31'b0, ready1}, {31'b0, k == 64});
        end
        raddr1[0] = 6'd3; raddr1[1] = 6'd9;
        #1;
        sb_push("coll_e3", 0, 32'd0);
        sb_push("coll_e9", 1, 32'd0);
        sb_check();
        check_value("coll_zr_ready", {31'b0, ready2}, 32'd1);

        // Restart a clear at count 20; includes a write attempt while clearing.
        wen1 = 1'b1; waddr1 = 6'd7; wdata1 = 32'h00000055;
        step();
        wen1 = 1'b0;
        clear1 = 1'b1;
        step();
        clear1 = 1'b0;
        repeat (4) step();
        wen1 = 1'b1; waddr1 = 6'd7; wdata1 = 32'h00000077;
        step();
        wen1 = 1'b0;
        check_value("rst_clr_drop", {31'b0, drop1}, 32'd1);
        repeat (15) step();
        check_value("rst_clr_mid", {31'b0, ready1}, 32'd0);
        clear1 = 1'b1;
        step();
        clear1 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            check_value("restart_ready", {31'b0, ready1}, {31'b0, k == 64});
        end
        raddr1[0] = 6'd7;
        #1;
        sb_push("restart_e7", 0, 32'd0);
        sb_check();

        // Zero register instance: entry 0 ignores writes without a drop, entry 1 behaves normally.
        wen2 = 1'b1; waddr2 = 6'd0; wdata2 = 32'h00000001;
        raddr2[0] = 6'd0;
        sb_push("zr_same", 2, 32'd0);
        @(negedge clk);
        sb_check();
        step();
        waddr2 = 6'd1; wdata2 = 32'h00000007;
        check_value("zr_nodrop", {31'b0, drop2}, 32'd0);
        sb_push("zr_e0", 2, 32'd0);
        @(negedge clk);
        sb_check();
        step();
        wen2 = 1'b0;
        raddr2[1] = 6'd1;
        check_value("zr_nodrop2", {31'b0, drop2}, 32'd0);
        sb_push("zr_e0_again", 2, 32'd0);
        sb_push("zr_e1", 3, 32'h00000007);
        @(negedge clk);
        sb_check();

        if (exp_q.size() != 0) check_value("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter addr_width_p, default 6, the address width; depth = 2**addr_width_p.
REQ-002 SHALL have parameter data_width_p, default 32, the entry width.
REQ-003 SHALL have parameter num_read_p, default 2, the number of independent read ports.
REQ-004 SHALL have parameter zero_reg_p, default 0; when 1, entry 0 reads as zero and is never written.
REQ-005 SHALL have ports (name, direction, width, meaning):
  clk  input  1  the single clock; all state updates on posedge.
  reset_n_i  input  1  asynchronous, active-low reset.
  clear_i  input  1  request to zero all entries.
  wen_i  input  1  write enable.
  write_addr_i  input  addr_width_p  write address.
  write_data_i  input  data_width_p  write data.
  read_addr_i  input  num_read_p x addr_width_p  per-port read address.
  read_data_o  output  num_read_p x data_width_p  per-port read data.
  ready_o  output  1  array usable; no clear in progress.
  wr_drop_o  output  1  one-cycle pulse: the previous cycle's write was discarded.

Function
REQ-006 SHALL read asynchronously: read_data_o[p] = entry[read_addr_i[p]], combinational, for all ports independently.
REQ-007 SHALL write synchronously on posedge clk when wen_i=1 and the state is READY and clear_i=0.
REQ-008 SHALL implement the FSM states CLEAR and READY.
REQ-009 In CLEAR, SHALL write zero to entry clr_cnt each posedge, then increment clr_cnt (width addr_width_p).
REQ-010 SHALL move CLEAR->READY on the posedge that clears entry depth-1, with no wrap to a second pass.
REQ-011 SHALL set ready_o=1 exactly when the state is READY (registered, glitch-free).
REQ-012 In READY with clear_i=1, SHALL enter CLEAR with clr_cnt=0 on the next posedge.
REQ-013 In CLEAR with clear_i=1, SHALL restart clr_cnt at 0.
REQ-014 While in CLEAR, SHALL drive read_data_o to all-zero on every port, regardless of contents.
REQ-015 A write with wen_i=1 in CLEAR, or in READY with clear_i=1, SHALL be discarded; the bench treats clear as winning.
REQ-016 SHALL register wr_drop_o=1 for exactly the one cycle following each discarded write; it is 0 otherwise.
REQ-017 With zero_reg_p=1, SHALL return zero on any port addressing entry 0 and SHALL ignore writes to it, with no wr_drop_o.
REQ-018 A write and a read of the same address in one cycle SHALL follow REQ-027/REQ-028; different addresses SHALL be unaffected.

Reset
REQ-019 reset_n_i=0 SHALL immediately force state CLEAR, clr_cnt=0, ready_o=0 and wr_drop_o=0, independent of clk.
REQ-020 During and after reset, read_data_o SHALL be all-zero until ready_o rises (REQ-014).
REQ-021 Entry storage SHALL NOT be reset directly; it is zeroed only by the CLEAR sequence.
REQ-022 After reset_n_i deasserts, ready_o SHALL rise after exactly depth posedges, provided clear_i=0.
REQ-023 Reset asserted mid-CLEAR or mid-write SHALL abort the operation and restart the sequence from entry 0.

Configuration
REQ-024 Macro REG_FILE_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-025 Forwarding SHALL apply only to accepted writes (REQ-007).
REQ-026 Forwarding SHALL NOT forward to entry 0 when zero_reg_p=1.
REQ-027 Macro defined: a read port addressing write_addr_i during an accepted write SHALL output write_data_i in the same cycle.
REQ-028 Macro undefined: that read port SHALL output the old contents; the new value is visible from the next cycle.

Verification
REQ-029 Reset sequence: pulse reset_n_i low mid-cycle, then release -> ready_o=0 and read_data_o=0 for 64 posedges; ready_o=1 after the 64th; all 64 entries read 0.
REQ-030 Write/read: write 0xDEADBEEF to entry 5 and 0x12345678 to entry 63 -> port0@5=0xDEADBEEF and port1@63=0x12345678 on the next cycle.
REQ-031 Bypass: write 0xA5A5A5A5 to entry 9 while port0 reads 9, old value 0x0 -> port0 reads 0xA5A5A5A5 with the macro defined and 0x0 without it.
REQ-032 Clear collision: in READY, assert clear_i together with wen_i (entry 3, 0xFF) -> wr_drop_o=1 for one cycle; ready_o=0 for 64 cycles; entry 3 then reads 0.
REQ-033 Clear restart: assert clear_i again at clr_cnt=20 -> ready_o returns after 64 more posedges, not 44.
REQ-034 Zero register: with zero_reg_p=1, write 0x1 to entry 0 -> reads 0; wr_drop_o stays 0.
